// File: rtl/shift_saturate_reg_if.sv
// rtl/shift_saturate_reg_if.sv - valid/ready word stream bundle
//
// Purpose : one direction of a valid/ready word stream.
// Signals : data  - W-bit payload, valid - payload present,
//           ready - sink accepts; a transfer happens when valid & ready.
// Modports: master drives data/valid, slave drives ready.
interface shift_saturate_reg_if #(
   parameter int W = 8
);
   logic [W-1:0] data;
   logic         valid;
   logic         ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/shift_saturate_reg.sv
// rtl/shift_saturate_reg.sv - drop rounded LSBs, saturate, register through a 2-entry skid
//
// Purpose : takes a rounded DIN-bit word, discards its NBITS LSBs, clamps the
//           remainder to DOUT bits (signed or unsigned) and presents it on a
//           registered stream with a registered din.ready.
// Ports   : clk     - rising-edge clock
//           rst     - asynchronous reset, active low
//           din     - input stream (slave), DIN-bit data
//           dout    - output stream (master), DOUT-bit data
//           sat_clr - synchronous clear of sat_cnt
//           sat_cnt - saturated words accepted since reset/clear (sticky at max)
module shift_saturate_reg #(
   parameter int DIN    = 16,
   parameter int NBITS  = 4,
   parameter int DOUT   = 8,
   parameter int SIGNED = 1,
   parameter int CNT_W  = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   shift_saturate_reg_if.slave         din,
   shift_saturate_reg_if.master        dout,
   input  logic                        sat_clr,
   output logic [CNT_W-1:0]            sat_cnt
);
   localparam int W = DIN - NBITS;

   logic [W-1:0]    t;
   logic [DOUT-1:0] sat_word;
   logic            sat;

   assign t = din.data[DIN-1:NBITS];

   // Dropped LSBs carry no information once rounding has been done upstream.
   logic unused_lsb;
   assign unused_lsb = ^din.data[NBITS-1:0];

   generate
      if (SIGNED != 0) begin : g_signed
         // t fits in DOUT signed bits iff bits [W-1:DOUT-1] are all copies of the sign.
         logic [W-DOUT:0] hi;
         assign hi = t[W-1:DOUT-1];
         always_comb begin
            sat_word = t[DOUT-1:0];
            sat      = 1'b0;
            if (!((&hi) || !(|hi))) begin
               // Clamp: sign=0 -> 0111..1 (MAX), sign=1 -> 1000..0 (MIN).
               sat                = 1'b1;
               sat_word           = {DOUT{~t[W-1]}};
               sat_word[DOUT-1]   = t[W-1];
            end
         end
      end else if (DOUT < W) begin : g_unsigned
         always_comb begin
            sat_word = t[DOUT-1:0];
            sat      = 1'b0;
            if (|t[W-1:DOUT]) begin
               sat      = 1'b1;
               sat_word = '1;
            end
         end
      end else begin : g_unsigned_full
         // Output as wide as t: nothing can overflow.
         assign sat_word = t;
         assign sat      = 1'b0;
      end
   endgenerate

   logic            out_valid;
   logic [DOUT-1:0] out_data;
   logic            skid_valid;
   logic [DOUT-1:0] skid_data;
   logic            rdy_q;      // always equal to !skid_valid, kept in its own flop
   logic            accept;
   logic            out_free;

   assign accept   = din.valid & rdy_q;
   assign out_free = ~out_valid | dout.ready;

   assign din.ready  = rdy_q;
   assign dout.valid = out_valid;
   assign dout.data  = out_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         rdy_q      <= 1'b1;
      end else begin
         if (out_free) begin
            if (skid_valid) begin
               // rdy_q is low here, so no new word competes for OUT.
               out_data   <= skid_data;
               out_valid  <= 1'b1;
               skid_valid <= 1'b0;
               rdy_q      <= 1'b1;
            end else if (accept) begin
               out_data  <= sat_word;
               out_valid <= 1'b1;
            end else begin
               out_valid <= 1'b0;
            end
         end else if (accept) begin
            skid_data  <= sat_word;
            skid_valid <= 1'b1;
            rdy_q      <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sat_cnt <= '0;
      end else if (sat_clr) begin
         sat_cnt <= '0;
      end else if (accept && sat && !(&sat_cnt)) begin
         sat_cnt <= sat_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_shift_saturate_reg.sv
// tb/tb_shift_saturate_reg.sv - self-checking bench for shift_saturate_reg
module tb_shift_saturate_reg;
   logic clk;
   logic rst;
   logic clr0, clr1;
   logic [15:0] sc0;
   logic [1:0]  sc1;

   int n_chk  = 0;
   int n_fail = 0;

   shift_saturate_reg_if #(.W(16)) i0 ();
   shift_saturate_reg_if #(.W(8))  o0 ();
   shift_saturate_reg_if #(.W(16)) i1 ();
   shift_saturate_reg_if #(.W(8))  o1 ();

   shift_saturate_reg u0 (
      .clk(clk), .rst(rst), .din(i0), .dout(o0), .sat_clr(clr0), .sat_cnt(sc0)
   );

   shift_saturate_reg #(.SIGNED(0), .CNT_W(2)) u1 (
      .clk(clk), .rst(rst), .din(i1), .dout(o1), .sat_clr(clr1), .sat_cnt(sc1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: integer value of the upper 12 bits, clamped to the output range.
   function automatic void ref_s(input logic [15:0] x, output logic [7:0] y, output bit s);
      int v;
      v = int'($signed(x)) >>> 4;
      s = 1'b1;
      if (v > 127)       y = 8'h7F;
      else if (v < -128) y = 8'h80;
      else begin
         y = 8'(v);
         s = 1'b0;
      end
   endfunction

   function automatic void ref_u(input logic [15:0] x, output logic [7:0] y, output bit s);
      int v;
      v = int'(x) / 16;
      s = (v > 255);
      y = s ? 8'hFF : 8'(v);
   endfunction

   logic [7:0] q0[$];   // words the DUT currently holds, oldest first
   int         cnt0;

   task automatic step0(input logic v, input logic [15:0] d, input logic r,
                        input logic clr, output logic took);
      logic [7:0] y;
      bit         s;
      logic [7:0] e;
      i0.valid = v;
      i0.data  = d;
      o0.ready = r;
      clr0     = clr;
      took     = v & i0.ready;
      s        = 1'b0;
      if (o0.valid && r) begin
         if (q0.size() == 0) check("spurious_out", o0.valid, 1'b0);
         else begin
            e = q0.pop_front();
            check("out_order", o0.data, e);
         end
      end
      if (took) begin
         ref_s(d, y, s);
         q0.push_back(y);
      end
      if (clr) cnt0 = 0;
      else if (took && s && cnt0 != 65535) cnt0++;
      @(posedge clk);
      #1;
      check("occupancy", q0.size() <= 2, 1'b1);
      check("valid", o0.valid, q0.size() != 0);
      check("ready", i0.ready, q0.size() < 2);
      if (q0.size() != 0) check("head", o0.data, q0[0]);
      check("sat_cnt", sc0, cnt0);
   endtask

   task automatic step1(input logic [15:0] d, input logic clr);
      i1.valid = 1'b1;
      i1.data  = d;
      o1.ready = 1'b1;
      clr1     = clr;
      @(posedge clk);
      #1;
      i1.valid = 1'b0;
      clr1     = 1'b0;
   endtask

   initial begin
      logic        took;
      logic [7:0]  y;
      bit          s;
      logic [15:0] tp_in  [4] = '{16'h0150, 16'h1000, 16'hF000, 16'hFF80};
      logic [7:0]  tp_out [4] = '{8'h15, 8'h7F, 8'h80, 8'hF8};
      logic [15:0] u_sat  [5] = '{16'h1000, 16'h2340, 16'hFFF0, 16'h1010, 16'h8000};
      logic [1:0]  u_cnt  [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      int          idx, words, cyc;

      rst = 1'b0;
      clr0 = 1'b0; clr1 = 1'b0;
      i0.valid = 1'b0; i0.data = '0; o0.ready = 1'b0;
      i1.valid = 1'b0; i1.data = '0; o1.ready = 1'b1;
      cnt0 = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", o0.valid, 1'b0);
      check("rst_data", o0.data, 8'h00);
      check("rst_ready", i0.ready, 1'b1);
      check("rst_cnt", sc0, 16'h0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_ready", i0.ready, 1'b1);

      // Back-to-back signed words, one output per cycle.
      for (int i = 0; i < 4; i++) begin
         step0(1'b1, tp_in[i], 1'b1, 1'b0, took);
         check("tp1_took", took, 1'b1);
         check("tp1_data", o0.data, tp_out[i]);
      end
      step0(1'b0, 16'h0, 1'b1, 1'b0, took);
      check("tp1_cnt", sc0, 16'd2);

      // Unsigned instance, 2-bit counter.
      step1(16'h0FF0, 1'b0);
      ref_u(16'h0FF0, y, s);
      check("u_data_nosat", o1.data, y);
      check("u_data_const", o1.data, 8'hFF);
      check("u_cnt_nosat", sc1, 2'd0);
      for (int i = 0; i < 5; i++) begin
         step1(u_sat[i], 1'b0);
         ref_u(u_sat[i], y, s);
         check("u_valid", o1.valid, 1'b1);
         check("u_data", o1.data, y);
         check("u_cnt", sc1, u_cnt[i]);
      end
      step1(16'h3000, 1'b1);
      check("u_clr_prio", sc1, 2'd0);

      // Backpressure: 3 stalled cycles, then drain.
      idx = 0;
      for (int c = 0; c < 14; c++) begin
         step0(idx < 5, 16'((idx + 1) * 16), c >= 3, 1'b0, took);
         if (took) idx++;
         if (c == 2) check("bp_ready_low", i0.ready, 1'b0);
      end
      check("bp_accepted", idx, 5);
      check("bp_drained", q0.size(), 0);

      // Randomised traffic against the queue model.
      words = 0;
      cyc   = 0;
      while (words < 10000 && cyc < 40000) begin
         logic [15:0] d;
         int          sel;
         sel = $urandom_range(0, 3);
         d   = 16'($urandom);
         if (sel == 1) d = 16'h0700 + 16'($urandom_range(0, 16'h0200));
         if (sel == 2) d = 16'hF700 + 16'($urandom_range(0, 16'h0200));
         step0($urandom_range(0, 9) < 7, d, $urandom_range(0, 9) < 6,
               $urandom_range(0, 499) == 0, took);
         if (took) words++;
         cyc++;
      end
      check("random_words", words, 10000);

      // Fill OUT and SKID, then reset mid-cycle.
      step0(1'b1, 16'h0200, 1'b0, 1'b0, took);
      step0(1'b1, 16'h0300, 1'b0, 1'b0, took);
      check("full_ready", i0.ready, 1'b0);
      rst = 1'b0;
      #1;
      check("async_valid", o0.valid, 1'b0);
      check("async_data", o0.data, 8'h00);
      check("async_cnt", sc0, 16'h0);
      #2;
      rst = 1'b1;
      q0.delete();
      cnt0 = 0;
      check("rel_ready", i0.ready, 1'b1);
      for (int c = 0; c < 4; c++) step0(1'b0, 16'h0, 1'b1, 1'b0, took);
      step0(1'b1, 16'h0420, 1'b1, 1'b0, took);
      check("after_rst_word", o0.data, 8'h42);
      step0(1'b0, 16'h0, 1'b1, 1'b0, took);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
